byte_store_aligner: RTL

BYTE_STORE_ALIGNER -- requirements
Module: byte_store_aligner

---
 rtl/byte_store_aligner_pkg.sv | 23 ++
 rtl/byte_store_aligner_rotate.sv | 28 ++
 rtl/byte_store_aligner.sv | 115 +++++++++++
 3 files changed

// File: rtl/byte_store_aligner_pkg.sv
// Shared store-path types: size encodings, beat FSM states and a size decode helper.
package byte_store_aligner_pkg;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2,
    SIZE_8B = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2
  } state_e;

  localparam int STORE_DATA_W = 64;

  function automatic logic [3:0] size_to_nbytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/byte_store_aligner_rotate.sv
// Log-depth byte rotator: rotates the line image left by i_shift bytes,
// the store-side counterpart of the load-path right rotator.
module byte_rotate_left #(
  parameter int NUM_BYTES = 16
) (
  input  logic [NUM_BYTES*8-1:0]       i_data,
  input  logic [$clog2(NUM_BYTES)-1:0] i_shift,
  output logic [NUM_BYTES*8-1:0]       o_data
);

  localparam int LW = $clog2(NUM_BYTES);
  localparam int DW = NUM_BYTES * 8;

  logic [DW-1:0] w_stage [0:LW];

  assign w_stage[0] = i_data;

  // Stage s rotates by 2^s bytes when shift bit s is set.
  for (genvar s = 0; s < LW; s++) begin : g_stage
    localparam int SH = 8 << s;
    assign w_stage[s+1] = i_shift[s] ?
                          {w_stage[s][DW-SH-1:0], w_stage[s][DW-1:DW-SH]} :
                          w_stage[s];
  end

  assign o_data = w_stage[LW];

endmodule

// File: rtl/byte_store_aligner.sv
// Aligns a 1..8 byte store into one or two cache-line write beats with byte masks.
//
// state    | meaning
// ST_IDLE  | no store held, ready for a request
// ST_BEAT0 | presenting the beat for the line holding the first store byte
// ST_BEAT1 | presenting the spill beat into the next line
module byte_store_aligner
  import byte_store_aligner_pkg::*;
#(
  parameter int NUM_BYTES = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic [1:0]             in_size,
  input  logic [63:0]            in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      out_line_addr,
  output logic [NUM_BYTES*8-1:0] out_data,
  output logic [NUM_BYTES-1:0]   out_mask,
  output logic                   out_last
);

  localparam int LW = $clog2(NUM_BYTES);
  localparam int DW = NUM_BYTES * 8;
  localparam int SW = LW + 1;

  state_e              r_state;
  logic [LW-1:0]       r_off;
  logic [SW-1:0]       r_span;
  logic [ADDR_W-1:0]   r_line_addr;
  logic [DW-1:0]       r_data;

  logic [LW-1:0]       w_off_in;
  logic [SW-1:0]       w_span_in;
  logic [ADDR_W-1:0]   w_line_in;
  logic [DW-1:0]       w_ext;
  logic [DW-1:0]       w_rot;
  logic                w_cross;
  logic                w_last_hs;
  logic                w_accept;
  logic [NUM_BYTES-1:0] w_mask;

  assign w_off_in  = in_addr[LW-1:0];
  assign w_span_in = SW'(w_off_in) + SW'(size_to_nbytes(size_e'(in_size)));
  assign w_line_in = in_addr & ~ADDR_W'(NUM_BYTES - 1);
  assign w_ext     = DW'(in_data);

  byte_rotate_left #(.NUM_BYTES(NUM_BYTES)) u_rotate (
    .i_data  (w_ext),
    .i_shift (w_off_in),
    .o_data  (w_rot)
  );

  assign w_cross   = r_span > SW'(NUM_BYTES);
  assign out_valid = (r_state != ST_IDLE);
  assign out_last  = (r_state == ST_BEAT1) || ((r_state == ST_BEAT0) && !w_cross);
  assign w_last_hs = out_valid && out_ready && out_last;
  // Held low through reset so nothing is accepted until reset is released.
  assign in_ready  = !rst && ((r_state == ST_IDLE) || w_last_hs);
  assign w_accept  = in_valid && in_ready;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      case (r_state)
        ST_BEAT0: w_mask[i] = (LW'(i) >= r_off) && (SW'(i) < r_span);
        ST_BEAT1: w_mask[i] = SW'(i + NUM_BYTES) < r_span;
        default:  w_mask[i] = 1'b0;
      endcase
    end
  end

  assign out_mask      = w_mask;
  assign out_data      = r_data;
  assign out_line_addr = r_line_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_off       <= '0;
      r_span      <= '0;
      r_line_addr <= '0;
      r_data      <= '0;
    end else if (w_accept) begin
      r_state     <= ST_BEAT0;
      r_off       <= w_off_in;
      r_span      <= w_span_in;
      r_line_addr <= w_line_in;
      r_data      <= w_rot;
    end else begin
      case (r_state)
        ST_BEAT0: begin
          if (out_ready) begin
            if (w_cross) begin
              r_state     <= ST_BEAT1;
              r_line_addr <= r_line_addr + ADDR_W'(NUM_BYTES);
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_BEAT1: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
